// File: rtl/sprite_pos_ctrl.sv
// rtl/sprite_pos_ctrl.sv - frame-synchronous sprite position scheduler
// Clamps a shadowed target on screen and slews the committed position once per vblank.
`timescale 1ns/1ps
module sprite_pos_ctrl #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int SPR_W    = 48,
  parameter int SPR_H    = 64,
  parameter int STEP_MAX = 8,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  input  logic        target_valid,
  input  logic        enable,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        moving,
  output logic        frame_tick,
  output logic [7:0]  frame_cnt
);

  localparam logic [1:0] WAIT_VB = 2'd0;
  localparam logic [1:0] CLAMP   = 2'd1;
  localparam logic [1:0] STEP    = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [12:0] X_MAX  = 13'(H_ACTIVE - SPR_W);
  localparam logic [12:0] Y_MAX  = 13'(V_ACTIVE - SPR_H);
  localparam logic [12:0] STEP13 = 13'(STEP_MAX);
  localparam logic [11:0] STEP12 = 12'(STEP_MAX);
  localparam logic [11:0] X_INIT = 12'(INIT_X);
  localparam logic [11:0] Y_INIT = 12'(INIT_Y);

  logic [1:0]  state_q, state_d;
  logic        vblnk_dly_q, vblnk_dly_d;
  logic [11:0] shx_q, shx_d, shy_q, shy_d;
  logic [11:0] tx_q, tx_d, ty_q, ty_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        moving_q, moving_d;
  logic        tick_q, tick_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vb_edge;
  logic [11:0] new_x, new_y;

  // One axis of the slew: a small remaining distance snaps onto the target,
  // anything larger moves by exactly STEP_MAX toward it.
  function automatic logic [11:0] slew(input logic [11:0] cur, input logic [11:0] tgt);
    logic [12:0] d;
    logic [12:0] mag;
    d   = {1'b0, tgt} - {1'b0, cur};
    mag = d[12] ? (13'd0 - d) : d;
    if (mag <= STEP13) return tgt;
    else if (d[12])    return cur - STEP12;
    else               return cur + STEP12;
  endfunction

  assign vb_edge = vblnk & ~vblnk_dly_q;
  assign new_x   = enable ? slew(xpos_q, tx_q) : xpos_q;
  assign new_y   = enable ? slew(ypos_q, ty_q) : ypos_q;

  always_comb begin
    state_d     = state_q;
    vblnk_dly_d = vblnk;
    shx_d       = target_valid ? target_x : shx_q;
    shy_d       = target_valid ? target_y : shy_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    moving_d    = moving_q;
    tick_d      = 1'b0;
    cnt_d       = cnt_q;
    case (state_q)
      WAIT_VB: begin
        if (vb_edge) begin
          state_d = CLAMP;
          tick_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      CLAMP: begin
        tx_d    = ({1'b0, shx_q} > X_MAX) ? X_MAX[11:0] : shx_q;
        ty_d    = ({1'b0, shy_q} > Y_MAX) ? Y_MAX[11:0] : shy_q;
        state_d = STEP;
      end
      STEP: begin
        xpos_d   = new_x;
        ypos_d   = new_y;
        moving_d = (new_x != tx_q) || (new_y != ty_q);
        state_d  = HOLD;
      end
      HOLD: begin
        // A second rising edge is only possible after vblank drops.
        if (!vblnk) state_d = WAIT_VB;
      end
      default: state_d = WAIT_VB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_VB;
      vblnk_dly_q <= 1'b1;
      shx_q       <= X_INIT;
      shy_q       <= Y_INIT;
      tx_q        <= X_INIT;
      ty_q        <= Y_INIT;
      xpos_q      <= X_INIT;
      ypos_q      <= Y_INIT;
      moving_q    <= 1'b0;
      tick_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      vblnk_dly_q <= vblnk_dly_d;
      shx_q       <= shx_d;
      shy_q       <= shy_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      moving_q    <= moving_d;
      tick_q      <= tick_d;
      cnt_q       <= cnt_d;
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign moving     = moving_q;
  assign frame_tick = tick_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// tb/tb_sprite_pos_ctrl.sv - self-checking bench for sprite_pos_ctrl
// Frame expectations are queued as vblank is raised and checked when frame_tick appears.
`timescale 1ns/1ps
module tb_sprite_pos_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vblnk;
  logic [11:0] target_x;
  logic [11:0] target_y;
  logic        target_valid;
  logic        enable;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        moving;
  logic        frame_tick;
  logic [7:0]  frame_cnt;

  sprite_pos_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vblnk        (vblnk),
    .target_x     (target_x),
    .target_y     (target_y),
    .target_valid (target_valid),
    .enable       (enable),
    .xpos         (xpos),
    .ypos         (ypos),
    .moving       (moving),
    .frame_tick   (frame_tick),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int py;
    int x;
    int y;
    int mov;
    int cnt;
  } exp_t;

  typedef struct {
    int tx;
    int ty;
    bit tv;
    bit en;
    int ex;
    int ey;
    int emov;
  } vec_t;

  localparam int XMAX = 976;
  localparam int YMAX = 704;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cur_x = 0;
  int   cur_y = 0;
  int   exp_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_slew(input int cur, input int tgt);
    if (tgt - cur > 8) return cur + 8;
    if (cur - tgt > 8) return cur - 8;
    return tgt;
  endfunction

  // Called at posedge+1; returns at posedge+1 with vblank low again.
  task automatic frame(input int ex, input int ey, input int emov);
    exp_t e;
    e.px = cur_x;
    e.py = cur_y;
    e.x = ex;
    e.y = ey;
    e.mov = emov;
    exp_cnt = (exp_cnt + 1) % 256;
    e.cnt = exp_cnt;
    sb.push_back(e);
    cur_x = ex;
    cur_y = ey;
    vblnk = 1'b1;
    repeat (6) @(posedge clk);
    #1 vblnk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic set_target(input int tx, input int ty);
    target_x = 12'(tx);
    target_y = 12'(ty);
    target_valid = 1'b1;
    @(posedge clk);
    #1 target_valid = 1'b0;
  endtask

  task automatic run_to(input int tx, input int ty);
    int cx;
    int cy;
    int nx;
    int ny;
    int mv;
    cx = (tx > XMAX) ? XMAX : tx;
    cy = (ty > YMAX) ? YMAX : ty;
    set_target(tx, ty);
    for (int f = 0; f < 200; f++) begin
      nx = ref_slew(cur_x, cx);
      ny = ref_slew(cur_y, cy);
      mv = ((nx != cx) || (ny != cy)) ? 1 : 0;
      frame(nx, ny, mv);
      if (mv == 0) break;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && frame_tick) begin
        chk("tick_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("frame_cnt", frame_cnt, e.cnt);
          @(negedge clk);
          chk("x_before_commit", xpos, e.px);
          chk("y_before_commit", ypos, e.py);
          @(negedge clk);
          chk("xpos", xpos, e.x);
          chk("ypos", ypos, e.y);
          chk("moving", moving, e.mov);
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t vt[4];
    vt[0] = '{tx: 20, ty: 5, tv: 1'b1, en: 1'b1, ex: 8,  ey: 5, emov: 1};
    vt[1] = '{tx: 0,  ty: 0, tv: 1'b0, en: 1'b1, ex: 16, ey: 5, emov: 1};
    vt[2] = '{tx: 0,  ty: 0, tv: 1'b0, en: 1'b1, ex: 20, ey: 5, emov: 0};
    vt[3] = '{tx: 0,  ty: 0, tv: 1'b0, en: 1'b1, ex: 20, ey: 5, emov: 0};

    rst_n = 1'b0;
    vblnk = 1'b1;
    target_x = '0;
    target_y = '0;
    target_valid = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // vblank already high at release must not count as a frame
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tick", frame_tick, 0);
      chk("rst_cnt", frame_cnt, 0);
    end
    chk("rst_x", xpos, 0);
    chk("rst_y", ypos, 0);
    chk("rst_moving", moving, 0);
    @(posedge clk);
    #1 vblnk = 1'b0;
    repeat (4) @(posedge clk);
    #1 mon_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      enable = vt[i].en;
      if (vt[i].tv) set_target(vt[i].tx, vt[i].ty);
      frame(vt[i].ex, vt[i].ey, vt[i].emov);
    end

    run_to(100, 100);
    chk("at_100_x", cur_x, 100);
    set_target(95, 0);
    frame(95, 92, 1);

    run_to(1023, 767);
    chk("clamp_settle_x", xpos, XMAX);
    chk("clamp_settle_y", ypos, YMAX);
    frame(XMAX, YMAX, 0);

    set_target(10, 10);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("active_hold_x", xpos, XMAX);
      chk("active_hold_y", ypos, YMAX);
    end
    @(posedge clk);
    #1;
    frame(968, 696, 1);

    // Reset asserted while the FSM sits in STEP
    mon_en = 1'b0;
    vblnk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("step_rst_x", xpos, 0);
    chk("step_rst_y", ypos, 0);
    chk("step_rst_cnt", frame_cnt, 0);
    chk("step_rst_tick", frame_tick, 0);
    chk("step_rst_moving", moving, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_commit_x", xpos, 0);
      chk("no_tick_after_rst", frame_tick, 0);
    end
    @(posedge clk);
    #1 vblnk = 1'b0;
    cur_x = 0;
    cur_y = 0;
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;

    enable = 1'b0;
    set_target(500, 300);
    for (int f = 0; f < 300; f++) frame(0, 0, 1);
    chk("cnt_wrap_44", frame_cnt, 44);
    chk("frozen_x", xpos, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
